// File: rtl/uart_ctrl.sv
// -----------------------------------------------------------------------------
// uart_ctrl
//
// Register-mapped control and scheduling block for the UART. It sits between
// the CPU request/ack bus and the UART engines, buffers TX and RX characters in
// small FIFOs, feeds the TX engine over a valid/ready handshake, and owns the
// baud-rate select. A baud change is staged in CTRL: TX issue pauses until both
// engines are idle, and only then is the new select applied, so no frame is
// ever sent or received at mixed rates.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_i, we_i       bus request pulse and write enable
//   addr_i, wdata_i   register word index and write data
//   rdata_o, ack_o    read data (valid only while ack_o is high) and ack
//   baud_sel_o        active baud select to the baud generator
//   tx_busy_i         TX engine mid-frame
//   rx_busy_i         RX engine mid-frame
//   tx_valid_o        TX FIFO head offered to the TX engine
//   tx_data_o         TX FIFO head
//   tx_ready_i        TX engine accepts the head
//   rx_valid_i        one-cycle pulse, received character available
//   rx_data_i         received character
//   irq_o             level interrupt (registered)
//   state_dbg         baud scheduler state (0=RUN, 1=DRAIN, 2=SWITCH)
//
// Handshake: a TX transfer happens on every rising clock edge where
// tx_valid_o and tx_ready_i are both high; tx_valid_o and tx_data_o depend on
// registered state only, never on tx_ready_i.
//
// Register map (word index)
//   0 CTRL    [1:0] requested baud, [2] tx_en, [3] rx_en, [4] rx_irq_en
//   1 STATUS  [0] tx_full, [1] tx_empty, [2] rx_nonempty, [3] rx_overrun (W1C),
//             [4] baud_pending, [6:5] active baud, [7] tx_drop (W1C)
//   2 TXDATA  write pushes a character; reads return 0
//   3 RXDATA  read returns {valid, data} and pops; writes ignored
// -----------------------------------------------------------------------------
module uart_ctrl #(
   parameter int FifoDepth = 4,
   parameter int DataWidth = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [1:0]           addr_i,
   input  logic [31:0]          wdata_i,
   output logic [31:0]          rdata_o,
   output logic                 ack_o,
   output logic [1:0]           baud_sel_o,
   input  logic                 tx_busy_i,
   input  logic                 rx_busy_i,
   output logic                 tx_valid_o,
   output logic [DataWidth-1:0] tx_data_o,
   input  logic                 tx_ready_i,
   input  logic                 rx_valid_i,
   input  logic [DataWidth-1:0] rx_data_i,
   output logic                 irq_o,
   output logic [1:0]           state_dbg
);

   localparam int AW = $clog2(FifoDepth);
   localparam logic [AW:0] PtrOne = 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [4:0] ctrl_q;
   logic       rx_overrun_q;
   logic       tx_drop_q;

   // FIFO storage and pointers (one extra wrap bit distinguishes full/empty)
   logic [DataWidth-1:0] tx_mem [FifoDepth];
   logic [DataWidth-1:0] rx_mem [FifoDepth];
   logic [AW:0]          tx_wp, tx_rp, rx_wp, rx_rp;
   logic                 tx_full, tx_empty, rx_full, rx_empty;
   logic [DataWidth-1:0] rx_head;

   logic        bus_go, bus_wr, bus_rd;
   logic        tx_push_req, tx_push, tx_pop, tx_drop_set;
   logic        rx_cap, rx_push, rx_pop, rx_ovr_set;
   logic        baud_pending;
   logic [7:0]  status;
   logic [31:0] rd_val;

   // Upper write-data bits are intentionally don't-care.
   logic unused_wdata;
   assign unused_wdata = ^wdata_i;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign rx_head  = rx_mem[rx_rp[AW-1:0]];

   // A request arriving while the previous ack is still out is ignored.
   assign bus_go = req_i && !ack_o;
   assign bus_wr = bus_go && we_i;
   assign bus_rd = bus_go && !we_i;

   assign tx_valid_o = ctrl_q[2] && !tx_empty && (state_q == ST_RUN);
   assign tx_data_o  = tx_mem[tx_rp[AW-1:0]];

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign tx_pop      = tx_valid_o && tx_ready_i;
   assign tx_push_req = bus_wr && (addr_i == 2'd2);
   assign tx_push     = tx_push_req && (!tx_full || tx_pop);
   assign tx_drop_set = tx_push_req && tx_full && !tx_pop;

   assign rx_pop     = bus_rd && (addr_i == 2'd3) && !rx_empty;
   assign rx_cap     = rx_valid_i && ctrl_q[3];
   assign rx_push    = rx_cap && (!rx_full || rx_pop);
   assign rx_ovr_set = rx_cap && rx_full && !rx_pop;

   assign baud_pending = (ctrl_q[1:0] != baud_sel_o);
   assign state_dbg    = state_q;

   always_comb begin
      status    = '0;
      status[0] = tx_full;
      status[1] = tx_empty;
      status[2] = !rx_empty;
      status[3] = rx_overrun_q;
      status[4] = baud_pending;
      status[6:5] = baud_sel_o;
      status[7] = tx_drop_q;
   end

   always_comb begin
      rd_val = '0;
      if (bus_rd) begin
         case (addr_i)
            2'd0: rd_val[4:0] = ctrl_q;
            2'd1: rd_val[7:0] = status;
            2'd3: begin
               if (!rx_empty) begin
                  rd_val[DataWidth]     = 1'b1;
                  rd_val[DataWidth-1:0] = rx_head;
               end
            end
            default: rd_val = '0;
         endcase
      end
   end

   // Baud scheduler: next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (baud_pending) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Rewriting CTRL back to the active rate cancels the change.
            if (!baud_pending)                state_d = ST_RUN;
            else if (!tx_busy_i && !rx_busy_i) state_d = ST_SWITCH;
         end
         ST_SWITCH: state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_RUN;
         baud_sel_o <= 2'b00;
      end else begin
         state_q <= state_d;
         if (state_q == ST_SWITCH) baud_sel_o <= ctrl_q[1:0];
      end
   end

   // Registers, sticky flags and bus response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q       <= '0;
         rx_overrun_q <= 1'b0;
         tx_drop_q    <= 1'b0;
         ack_o        <= 1'b0;
         rdata_o      <= '0;
         irq_o        <= 1'b0;
      end else begin
         ack_o   <= bus_go;
         rdata_o <= rd_val;
         irq_o   <= (ctrl_q[4] && !rx_empty) || rx_overrun_q || tx_drop_q;

         if (bus_wr && (addr_i == 2'd0)) ctrl_q <= wdata_i[4:0];

         // A new event in the same cycle as a clear wins, so it is not lost.
         if (bus_wr && (addr_i == 2'd1) && wdata_i[3]) rx_overrun_q <= 1'b0;
         if (rx_ovr_set)                               rx_overrun_q <= 1'b1;
         if (bus_wr && (addr_i == 2'd1) && wdata_i[7]) tx_drop_q    <= 1'b0;
         if (tx_drop_set)                              tx_drop_q    <= 1'b1;
      end
   end

   // TX FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_wp <= '0;
         tx_rp <= '0;
         for (int i = 0; i < FifoDepth; i++) tx_mem[i] <= '0;
      end else begin
         if (tx_push) begin
            tx_mem[tx_wp[AW-1:0]] <= wdata_i[DataWidth-1:0];
            tx_wp <= tx_wp + PtrOne;
         end
         if (tx_pop) tx_rp <= tx_rp + PtrOne;
      end
   end

   // RX FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_wp <= '0;
         rx_rp <= '0;
         for (int i = 0; i < FifoDepth; i++) rx_mem[i] <= '0;
      end else begin
         if (rx_push) begin
            rx_mem[rx_wp[AW-1:0]] <= rx_data_i;
            rx_wp <= rx_wp + PtrOne;
         end
         if (rx_pop) rx_rp <= rx_rp + PtrOne;
      end
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_ctrl
//
// Self-checking bench for uart_ctrl. A behavioural model (queues for the two
// FIFOs, plain variables for CTRL, sticky flags and the active baud rate) is
// advanced on every rising edge from the inputs the DUT saw; a compare process
// checks the DUT outputs against it on every falling edge. The directed
// sequence also pins hand-computed literal values along the way.
// -----------------------------------------------------------------------------
module tb_uart_ctrl;

   localparam int DEPTH = 4;
   localparam int DW    = 8;

   // ---------------------------------------------------------------- clock/reset
   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          req_i, we_i;
   logic [1:0]    addr_i;
   logic [31:0]   wdata_i;
   logic [31:0]   rdata_o;
   logic          ack_o;
   logic [1:0]    baud_sel_o;
   logic          tx_busy_i, rx_busy_i;
   logic          tx_valid_o;
   logic [DW-1:0] tx_data_o;
   logic          tx_ready_i;
   logic          rx_valid_i;
   logic [DW-1:0] rx_data_i;
   logic          irq_o;
   logic [1:0]    state_dbg;

   always #5 clk_i = ~clk_i;

   uart_ctrl #(.FifoDepth(DEPTH), .DataWidth(DW)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .ack_o      (ack_o),
      .baud_sel_o (baud_sel_o),
      .tx_busy_i  (tx_busy_i),
      .rx_busy_i  (rx_busy_i),
      .tx_valid_o (tx_valid_o),
      .tx_data_o  (tx_data_o),
      .tx_ready_i (tx_ready_i),
      .rx_valid_i (rx_valid_i),
      .rx_data_i  (rx_data_i),
      .irq_o      (irq_o),
      .state_dbg  (state_dbg)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- scoreboard
   logic [DW-1:0] tx_exp_q[$];
   logic [DW-1:0] rx_exp_q[$];
   logic [4:0]    m_ctrl;
   logic          m_ovr, m_drop;
   logic [1:0]    m_baud;
   // Scheduler phase: changes are held off (hold) until both engines are
   // idle, then applied one edge later (apply).
   logic          m_hold, m_apply;
   logic          m_ack, m_irq;
   logic [31:0]   m_rdata;
   logic          model_live = 1'b0;

   logic          s_txv, s_pop, s_bus, s_rdpop, s_pend, s_txfull, s_rxfull;
   logic [31:0]   s_rd;
   logic [4:0]    s_ctrl;

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = '0;
      s[0]   = (tx_exp_q.size() == DEPTH);
      s[1]   = (tx_exp_q.size() == 0);
      s[2]   = (rx_exp_q.size() != 0);
      s[3]   = m_ovr;
      s[4]   = (m_ctrl[1:0] != m_baud);
      s[6:5] = m_baud;
      s[7]   = m_drop;
      return s;
   endfunction

   function automatic logic m_txv();
      return m_ctrl[2] && (tx_exp_q.size() != 0) && !m_hold && !m_apply;
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) begin
         tx_exp_q.delete();
         rx_exp_q.delete();
         m_ctrl = '0; m_ovr = 0; m_drop = 0; m_baud = 2'b00;
         m_hold = 0; m_apply = 0; m_ack = 0; m_irq = 0; m_rdata = '0;
         model_live = 1'b1;
      end else if (model_live) begin
         // Everything below is decided from pre-edge values.
         s_ctrl   = m_ctrl;
         s_pend   = (m_ctrl[1:0] != m_baud);
         s_txv    = m_txv();
         s_pop    = s_txv && tx_ready_i;
         s_bus    = req_i && !m_ack;
         s_rdpop  = s_bus && !we_i && addr_i == 2'd3 && rx_exp_q.size() != 0;
         s_txfull = (tx_exp_q.size() == DEPTH);
         s_rxfull = (rx_exp_q.size() == DEPTH);
         s_rd     = '0;
         if (s_bus && !we_i) begin
            case (addr_i)
               2'd0: s_rd = {27'b0, m_ctrl};
               2'd1: s_rd = m_status();
               2'd3: if (rx_exp_q.size() != 0) s_rd = {23'b0, 1'b1, rx_exp_q[0]};
               default: s_rd = '0;
            endcase
         end
         m_irq   = (m_ctrl[4] && rx_exp_q.size() != 0) || m_ovr || m_drop;
         m_ack   = s_bus;
         m_rdata = s_rd;

         // Baud scheduling
         if (m_apply) begin
            m_baud  = s_ctrl[1:0];
            m_apply = 0;
         end else if (m_hold) begin
            if (!s_pend) m_hold = 0;
            else if (!tx_busy_i && !rx_busy_i) begin
               m_hold  = 0;
               m_apply = 1;
            end
         end else if (s_pend) begin
            m_hold = 1;
         end

         // TX path
         if (s_pop) void'(tx_exp_q.pop_front());
         if (s_bus && we_i && addr_i == 2'd2) begin
            if (!s_txfull || s_pop) tx_exp_q.push_back(wdata_i[DW-1:0]);
            else m_drop = 1;
         end

         // RX path
         if (s_rdpop) void'(rx_exp_q.pop_front());
         if (rx_valid_i && s_ctrl[3]) begin
            if (!s_rxfull || s_rdpop) rx_exp_q.push_back(rx_data_i);
            else m_ovr = 1;
         end

         // Register writes (W1C clear loses to a same-cycle set)
         if (s_bus && we_i && addr_i == 2'd1) begin
            if (wdata_i[3] && !(rx_valid_i && s_ctrl[3] && s_rxfull && !s_rdpop)) m_ovr = 0;
            if (wdata_i[7]) m_drop = 0;
         end
         if (s_bus && we_i && addr_i == 2'd0) m_ctrl = wdata_i[4:0];
      end
   end

   // Compare process: every falling edge once the model is live.
   always @(negedge clk_i) begin
      if (model_live) begin
         check("ack_o",      {31'b0, ack_o},       {31'b0, m_ack});
         check("rdata_o",    rdata_o,              m_rdata);
         check("tx_valid_o", {31'b0, tx_valid_o},  {31'b0, m_txv()});
         if (tx_exp_q.size() != 0)
            check("tx_data_o", {24'b0, tx_data_o}, {24'b0, tx_exp_q[0]});
         check("baud_sel_o", {30'b0, baud_sel_o},  {30'b0, m_baud});
         check("irq_o",      {31'b0, irq_o},       {31'b0, m_irq});
      end
   end

   // ----------------------------------------------------------------- drivers
   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk_i); #2;
      req_i = 1; we_i = 1; addr_i = a; wdata_i = d;
      @(posedge clk_i); #2;
      req_i = 0; we_i = 0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(posedge clk_i); #2;
      req_i = 1; we_i = 0; addr_i = a;
      @(posedge clk_i); #2;
      req_i = 0;
      d = rdata_o;
   endtask

   task automatic rx_pulse(input logic [DW-1:0] b);
      rx_valid_i = 1; rx_data_i = b;
      tick(1);
      rx_valid_i = 0;
   endtask

   // ---------------------------------------------------------------- stimulus
   logic [31:0] rd;

   initial begin
      rst_i = 1; req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0;
      tx_busy_i = 0; rx_busy_i = 0; tx_ready_i = 0;
      rx_valid_i = 0; rx_data_i = 0;
      tick(3);
      rst_i = 0;

      // Reset state; a byte arriving while rx_en=0 is ignored
      rx_pulse(8'h99);
      bus_read(2'd1, rd);
      check("reset_status", rd, 32'h0000_0002);
      check("reset_baud",   {30'b0, baud_sel_o}, 32'h0);
      check("reset_irq",    {31'b0, irq_o}, 32'h0);

      // TX fill past full with the engine stalled
      bus_write(2'd0, 32'h4);
      for (int i = 0; i < 5; i++) bus_write(2'd2, 32'h41 + i);
      check("tx_head", {24'b0, tx_data_o}, 32'h41);
      bus_read(2'd1, rd);
      check("tx_full_drop_status", rd, 32'h0000_0081);
      check("tx_drop_irq", {31'b0, irq_o}, 32'h1);
      tx_ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         check("tx_emit_valid", {31'b0, tx_valid_o}, 32'h1);
         check("tx_emit_data",  {24'b0, tx_data_o}, 32'h41 + i);
         tick(1);
      end
      check("tx_drained", {31'b0, tx_valid_o}, 32'h0);
      tx_ready_i = 0;
      bus_write(2'd1, 32'h80);

      // Baud change waits for both engines
      tx_busy_i = 1; rx_busy_i = 1;
      bus_write(2'd2, 32'h55);
      bus_write(2'd0, 32'h7);
      tick(2);
      check("drain_tx_valid", {31'b0, tx_valid_o}, 32'h0);
      bus_read(2'd1, rd);
      check("drain_status", rd, 32'h0000_0010);
      tx_busy_i = 0;
      tick(3);
      check("rx_busy_holds", {30'b0, baud_sel_o}, 32'h0);
      rx_busy_i = 0;
      tick(1);
      check("baud_1cyc", {30'b0, baud_sel_o}, 32'h0);
      tick(1);
      check("baud_2cyc", {30'b0, baud_sel_o}, 32'h3);
      bus_read(2'd1, rd);
      check("switched_status", rd, 32'h0000_0060);
      check("tx_resume", {24'b0, tx_data_o}, 32'h55);
      tx_ready_i = 1;
      tick(1);
      tx_ready_i = 0;

      // Cancelled change: rewrite CTRL to the active rate during DRAIN
      tx_busy_i = 1;
      bus_write(2'd0, 32'h4);
      tick(2);
      bus_read(2'd1, rd);
      check("cancel_pending", rd, 32'h0000_0072);
      bus_write(2'd0, 32'h7);
      tick(1);
      bus_read(2'd1, rd);
      check("cancel_status", rd, 32'h0000_0062);
      tick(5);
      tx_busy_i = 0;
      tick(3);
      check("cancel_baud", {30'b0, baud_sel_o}, 32'h3);

      // RX overrun and interrupt
      bus_write(2'd0, 32'h1F);
      for (int i = 0; i < 5; i++) rx_pulse(8'h10 + i);
      tick(2);
      check("rx_irq", {31'b0, irq_o}, 32'h1);
      bus_read(2'd1, rd);
      check("rx_ovr_status", rd, 32'h0000_006E);
      for (int i = 0; i < 4; i++) begin
         bus_read(2'd3, rd);
         check("rx_read", rd, 32'h110 + i);
      end
      bus_read(2'd3, rd);
      check("rx_empty_read", rd, 32'h0);
      bus_write(2'd1, 32'h08);
      tick(2);
      check("irq_cleared", {31'b0, irq_o}, 32'h0);

      // RX full with a simultaneous RXDATA read: byte accepted
      for (int i = 0; i < 4; i++) rx_pulse(8'h20 + i);
      @(posedge clk_i); #2;
      req_i = 1; we_i = 0; addr_i = 2'd3;
      rx_valid_i = 1; rx_data_i = 8'h24;
      @(posedge clk_i); #2;
      req_i = 0; rx_valid_i = 0;
      check("rx_pop_push_read", rdata_o, 32'h120);
      bus_read(2'd1, rd);
      check("rx_no_overrun", rd, 32'h0000_0066);
      for (int i = 1; i < 5; i++) begin
         bus_read(2'd3, rd);
         check("rx_read2", rd, 32'h120 + i);
      end

      // A request held across the ack cycle is taken once
      bus_write(2'd0, 32'h3);
      @(posedge clk_i); #2;
      req_i = 1; we_i = 1; addr_i = 2'd2; wdata_i = 32'hAA;
      tick(2);
      req_i = 0; we_i = 0;
      for (int i = 0; i < 3; i++) bus_write(2'd2, 32'hB0 + i);
      bus_read(2'd1, rd);
      check("held_req_once", rd, 32'h0000_0061);

      // Reset in the middle of a pending change
      tx_busy_i = 1;
      bus_write(2'd0, 32'h1);
      tick(2);
      rst_i = 1;
      tick(2);
      rst_i = 0; tx_busy_i = 0;
      check("rst_baud", {30'b0, baud_sel_o}, 32'h0);
      bus_read(2'd0, rd);
      check("rst_ctrl", rd, 32'h0);
      tick(3);
      check("rst_no_switch", {30'b0, baud_sel_o}, 32'h0);
      bus_read(2'd1, rd);
      check("rst_status", rd, 32'h0000_0002);

      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
